// File: rtl/vi_wb_buf.sv
// Register-file writeback buffer: circular FIFO with a hazard lookup port.
// Define VI_WBBUF_FORWARD_EN to drive chk_data_o with the youngest matching entry's data.
module vi_wb_buf #(
  parameter int REG_DW = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [REG_AW-1:0]          in_addr_i,
  input  logic [REG_DW-1:0]          in_data_i,
  input  logic                       wb_stall_i,
  input  logic                       flush_i,
  output logic                       wb_en_o,
  output logic [REG_AW-1:0]          wb_addr_o,
  output logic [REG_DW-1:0]          wb_data_o,
  input  logic [REG_AW-1:0]          chk_addr_i,
  output logic                       chk_hit_o,
  output logic [REG_DW-1:0]          chk_data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] r_addr [DEPTH];
  logic [REG_DW-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_hit;

  assign w_empty    = (r_count == '0);
  assign in_ready_o = (r_count < CW'(DEPTH));
  // x0 writes complete the handshake but are never stored.
  assign w_push     = in_valid_i && in_ready_o && !flush_i && (in_addr_i != '0);
  assign wb_en_o    = !w_empty && !wb_stall_i && !flush_i;
  assign w_pop      = wb_en_o;
  assign wb_addr_o  = w_empty ? '0 : r_addr[r_rptr];
  assign wb_data_o  = w_empty ? '0 : r_data[r_rptr];
  assign count_o    = r_count;

  // Pointers are power-of-two wide, so increment wraps DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; validity comes solely from pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= in_addr_i;
      r_data[r_wptr] <= in_data_i;
    end
  end

`ifdef VI_WBBUF_FORWARD_EN
  logic [REG_DW-1:0] w_fwd;
`endif

  // NOTE: every comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_hit = 1'b0;
`ifdef VI_WBBUF_FORWARD_EN
    w_fwd = '0;
`endif
    // Walk oldest to youngest so the last match wins as the forwarded value.
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = r_rptr + PW'(k);
      if ((CW'(k) < r_count) && (chk_addr_i != '0) && (r_addr[idx] == chk_addr_i)) begin
        w_hit = 1'b1;
`ifdef VI_WBBUF_FORWARD_EN
        w_fwd = r_data[idx];
`endif
      end
    end
  end

  assign chk_hit_o = w_hit;
`ifdef VI_WBBUF_FORWARD_EN
  assign chk_data_o = w_fwd;
`else
  assign chk_data_o = '0;
`endif

endmodule
